// File: rtl/rx_trainerror_hs.sv
// Responder side of the TRAINERROR sideband handshake: answers the partner's entry
// request with an entry response, defers to the transmit side, and watches for a silent partner.
module rx_trainerror_hs #(
    parameter int unsigned SB_MSG_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8000,
    parameter int unsigned CNT_WIDTH      = 13
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_trainerror_en,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_tx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic                    o_trainerror_end_rx,
    output logic                    o_timeout
);

    typedef enum logic [2:0] {
        StIdle          = 3'd0,
        StWaitForReq    = 3'd1,
        StWaitForTxDone = 3'd2,
        StSendResp      = 3'd3,
        StTestFinished  = 3'd4
    } state_e;

    localparam logic [SB_MSG_WIDTH-1:0] MsgEntryReq  = SB_MSG_WIDTH'(15);
    localparam logic [SB_MSG_WIDTH-1:0] MsgEntryResp = SB_MSG_WIDTH'(14);
    localparam logic [CNT_WIDTH-1:0]    TermCnt      = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
    logic                    valid_q, valid_d;
    logic                    end_q, end_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic   req_seen;
    logic   busy_released;
    state_e resp_target;

    assign req_seen      = (i_decoded_SB_msg == MsgEntryReq);
    // A busy edge while the transmit side holds the sideband is not ours.
    assign busy_released = i_falling_edge_busy && !i_tx_valid;
    assign resp_target   = i_tx_valid ? StWaitForTxDone : StSendResp;

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        valid_d   = valid_q;
        end_d     = end_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                msg_d     = '0;
                end_d     = 1'b0;
                timeout_d = 1'b0;
                if (i_trainerror_en) begin
                    state_d = req_seen ? resp_target : StWaitForReq;
                end
            end
            StWaitForReq: begin
                if (!i_trainerror_en) begin
                    state_d = StIdle;
                end else if (req_seen) begin
                    state_d = resp_target;
                end else if (cnt_q == TermCnt) begin
                    state_d   = StTestFinished;
                    end_d     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            StWaitForTxDone: begin
                if (!i_trainerror_en) begin
                    state_d = StIdle;
                end else if (i_falling_edge_busy && i_tx_valid) begin
                    state_d = StSendResp;
                end
            end
            StSendResp: begin
                if (!i_trainerror_en) begin
                    state_d = StIdle;
                end else if (busy_released) begin
                    state_d = StTestFinished;
                    end_d   = 1'b1;
                end
            end
            StTestFinished: begin
                if (!i_trainerror_en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (busy_released) begin
            valid_d = 1'b0;
        end
        if (state_d == StSendResp && state_q != StSendResp) begin
            msg_d   = MsgEntryResp;
            valid_d = 1'b1;
        end

        // Counter only advances while remaining in WAIT_FOR_REQ, so it never wraps.
        cnt_d = (state_q == StWaitForReq && state_d == StWaitForReq) ?
                cnt_q + CNT_WIDTH'(1) : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            msg_q     <= '0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            valid_q   <= valid_d;
            end_q     <= end_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_encoded_SB_msg_rx = msg_q;
    assign o_valid_rx          = valid_q;
    assign o_trainerror_end_rx = end_q;
    assign o_timeout           = timeout_q;

endmodule

// File: tb/tb_rx_trainerror_hs.sv
// Bench for rx_trainerror_hs: directed handshake scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the handshake.
module tb_rx_trainerror_hs;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_i = 1'b0;
    logic       busy_i = 1'b0;
    logic       txv_i = 1'b0;
    logic [3:0] msg_i = 4'd0;
    logic [3:0] msg_o;
    logic       valid_o;
    logic       end_o;
    logic       to_o;

    int n_tests = 0;
    int n_fail  = 0;

    rx_trainerror_hs #(
        .SB_MSG_WIDTH  (4),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (5)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_trainerror_en    (en_i),
        .i_falling_edge_busy(busy_i),
        .i_tx_valid         (txv_i),
        .i_decoded_SB_msg   (msg_i),
        .o_encoded_SB_msg_rx(msg_o),
        .o_valid_rx         (valid_o),
        .o_trainerror_end_rx(end_o),
        .o_timeout          (to_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: where the handshake is, and how long we have listened in vain.
    localparam int PH_OFF    = 100;
    localparam int PH_LISTEN = 101;
    localparam int PH_DEFER  = 102;
    localparam int PH_ANSWER = 103;
    localparam int PH_DONE   = 104;

    typedef struct {
        int         phase;
        int         waited;
        logic [3:0] msg;
        logic       valid;
        logic       fin;
        logic       to;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t s, logic en, logic busy, logic txv,
                                          logic [3:0] msg);
        model_t n;
        logic   req;
        logic   released;
        logic   start_answer;
        n            = s;
        req          = (msg == 4'd15);
        released     = busy && !txv;
        start_answer = 1'b0;
        n.waited     = 0;
        if (released) n.valid = 1'b0;
        if (s.phase == PH_OFF) begin
            n.msg = 4'd0;
            n.fin = 1'b0;
            n.to  = 1'b0;
        end
        if (s.phase != PH_OFF && !en) begin
            n.phase = PH_OFF;
        end else begin
            case (s.phase)
                PH_OFF: begin
                    if (en && req) begin
                        if (txv) n.phase = PH_DEFER;
                        else start_answer = 1'b1;
                    end else if (en) begin
                        n.phase = PH_LISTEN;
                    end
                end
                PH_LISTEN: begin
                    if (req) begin
                        if (txv) n.phase = PH_DEFER;
                        else start_answer = 1'b1;
                    end else if (s.waited + 1 == int'(TO)) begin
                        n.phase = PH_DONE;
                        n.fin   = 1'b1;
                        n.to    = 1'b1;
                    end else begin
                        n.waited = s.waited + 1;
                    end
                end
                PH_DEFER:  if (busy && txv) start_answer = 1'b1;
                PH_ANSWER: begin
                    if (released) begin
                        n.phase = PH_DONE;
                        n.fin   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (start_answer) begin
            n.phase = PH_ANSWER;
            n.msg   = 4'd14;
            n.valid = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '{phase: PH_OFF, waited: 0, msg: 4'd0, valid: 1'b0, fin: 1'b0, to: 1'b0};
        end else begin
            m <= model_next(m, en_i, busy_i, txv_i, msg_i);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model msg_rx", 32'(msg_o), 32'(m.msg));
        chk("model valid_rx", 32'(valid_o), 32'(m.valid));
        chk("model end_rx", 32'(end_o), 32'(m.fin));
        chk("model timeout", 32'(to_o), 32'(m.to));
    end

    task automatic drive(input logic en, input logic [3:0] msg, input logic txv, input logic busy);
        en_i   = en;
        msg_i  = msg;
        txv_i  = txv;
        busy_i = busy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic tx_hold;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset msg", 32'(msg_o), 32'd0);
        chk("reset end", 32'(end_o), 32'd0);
        chk("reset timeout", 32'(to_o), 32'd0);

        // Clean response
        drive(1'b1, 4'd15, 1'b0, 1'b0);
        chk("clean valid", 32'(valid_o), 32'd1);
        chk("clean msg", 32'(msg_o), 32'd14);
        repeat (4) drive(1'b1, 4'd0, 1'b0, 1'b0);
        chk("clean valid held", 32'(valid_o), 32'd1);
        drive(1'b1, 4'd0, 1'b0, 1'b1);
        chk("clean valid cleared", 32'(valid_o), 32'd0);
        chk("clean end", 32'(end_o), 32'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        chk("clean end lingers", 32'(end_o), 32'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        chk("clean end cleared", 32'(end_o), 32'd0);
        chk("clean msg cleared", 32'(msg_o), 32'd0);

        // Late request
        repeat (10) drive(1'b1, 4'd0, 1'b0, 1'b0);
        chk("late no valid yet", 32'(valid_o), 32'd0);
        drive(1'b1, 4'd15, 1'b0, 1'b0);
        chk("late valid", 32'(valid_o), 32'd1);
        drive(1'b1, 4'd0, 1'b0, 1'b1);
        chk("late end", 32'(end_o), 32'd1);
        chk("late no timeout", 32'(to_o), 32'd0);
        repeat (2) drive(1'b0, 4'd0, 1'b0, 1'b0);

        // Request arriving on the watchdog terminal count wins
        repeat (TO) drive(1'b1, 4'd0, 1'b0, 1'b0);
        chk("term no timeout yet", 32'(to_o), 32'd0);
        drive(1'b1, 4'd15, 1'b0, 1'b0);
        chk("term req valid", 32'(valid_o), 32'd1);
        chk("term req no timeout", 32'(to_o), 32'd0);
        drive(1'b1, 4'd0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 4'd0, 1'b0, 1'b0);

        // Timeout
        repeat (TO) drive(1'b1, 4'd0, 1'b0, 1'b0);
        chk("timeout not early", 32'(to_o), 32'd0);
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        chk("timeout flag", 32'(to_o), 32'd1);
        chk("timeout end", 32'(end_o), 32'd1);
        chk("timeout msg", 32'(msg_o), 32'd0);
        repeat (2) drive(1'b0, 4'd0, 1'b0, 1'b0);
        chk("timeout cleared", 32'(to_o), 32'd0);
        chk("timeout end cleared", 32'(end_o), 32'd0);

        // Contention with the transmit side
        drive(1'b1, 4'd15, 1'b1, 1'b0);
        chk("contend no valid", 32'(valid_o), 32'd0);
        drive(1'b1, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd0, 1'b1, 1'b1);
        chk("contend valid", 32'(valid_o), 32'd1);
        chk("contend msg", 32'(msg_o), 32'd14);
        drive(1'b1, 4'd0, 1'b1, 1'b1);
        chk("contend tx busy keeps valid", 32'(valid_o), 32'd1);
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 1'b0, 1'b1);
        chk("contend end", 32'(end_o), 32'd1);
        chk("contend valid cleared", 32'(valid_o), 32'd0);
        repeat (2) drive(1'b0, 4'd0, 1'b0, 1'b0);

        // Abort mid-response, then a fresh response
        drive(1'b1, 4'd15, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        chk("abort msg holds", 32'(msg_o), 32'd14);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        chk("abort msg cleared", 32'(msg_o), 32'd0);
        drive(1'b1, 4'd15, 1'b0, 1'b0);
        chk("abort fresh msg", 32'(msg_o), 32'd14);
        chk("abort fresh valid", 32'(valid_o), 32'd1);
        drive(1'b1, 4'd0, 1'b0, 1'b1);
        chk("abort fresh end", 32'(end_o), 32'd1);
        repeat (2) drive(1'b0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset between edges while responding
        drive(1'b1, 4'd15, 1'b0, 1'b0);
        chk("async pre valid", 32'(valid_o), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async valid", 32'(valid_o), 32'd0);
        chk("async msg", 32'(msg_o), 32'd0);
        chk("async end", 32'(end_o), 32'd0);
        chk("async timeout", 32'(to_o), 32'd0);
        en_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic against the model
        tx_hold = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                #3 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) tx_hold = !tx_hold;
            drive($urandom_range(0, 39) != 0,
                  ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14)),
                  tx_hold,
                  $urandom_range(0, 4) == 0);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
